// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter/receiver state encoding and default
// oversampling timing.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } tx_state_t;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int SB_TICKS_DEF   = 16;

  // Tick counter must hold the longer of a data bit and the stop period.
  function automatic int tick_width(input int os, input int sb);
    return $clog2((os > sb) ? os : sb);
  endfunction

endpackage

// File: rtl/uart_tx_hold.sv
// One-entry holding register that queues the next byte while a frame is
// on the line; ready is derived purely from the registered valid flag.
module uart_tx_hold #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic             hold_valid,
  output logic [WIDTH-1:0] hold_data,
  output logic             ready
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (wr_en) begin
      hold_valid <= 1'b1;
      hold_data  <= wr_data;
    end else if (rd_en) begin
      hold_valid <= 1'b0;
    end
  end

  assign ready = !hold_valid;

endmodule

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter paced by the 16x baud tick, with a one-entry holding
// register so consecutive frames leave the pin with no idle gap.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int SB_TICKS   = SB_TICKS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] d_in,
  output logic                 tx,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int SW = tick_width(OVERSAMPLE, SB_TICKS);
  localparam int NW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] BIT_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] STOP_LAST = SW'(SB_TICKS - 1);
  localparam logic [NW-1:0] N_LAST    = NW'(DATA_BITS - 1);

  tx_state_t            state;
  logic [SW-1:0]        s;
  logic [NW-1:0]        n;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 hold_valid;
  logic [DATA_BITS-1:0] hold_data;
  logic                 accept;
  logic                 bit_end;
  logic                 stop_end;
  logic                 hold_wr;
  logic                 hold_rd;

  assign accept   = tx_start && tx_ready;
  assign bit_end  = baud && (s == BIT_LAST);
  assign stop_end = baud && (s == STOP_LAST);

  // A write on the final stop tick with the hold empty goes straight to the shifter.
  assign hold_wr = accept && (state != IDLE) && !((state == STOP) && stop_end);
  assign hold_rd = (state == STOP) && stop_end && hold_valid;

  uart_tx_hold #(
    .WIDTH(DATA_BITS)
  ) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (hold_wr),
    .wr_data   (d_in),
    .rd_en     (hold_rd),
    .hold_valid(hold_valid),
    .hold_data (hold_data),
    .ready     (tx_ready)
  );

  // tx is loaded with the level of the state being entered, so the pin
  // changes on the same edge as the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      s         <= '0;
      n         <= '0;
      shift_reg <= '0;
      tx        <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      unique case (state)
        IDLE: begin
          tx <= 1'b1;
          if (accept) begin
            shift_reg <= d_in;
            s         <= '0;
            state     <= START;
            tx        <= 1'b0;
            tx_busy   <= 1'b1;
          end
        end
        START: begin
          if (baud) begin
            if (bit_end) begin
              s     <= '0;
              n     <= '0;
              state <= DATA;
              tx    <= shift_reg[0];
            end else begin
              s <= s + SW'(1);
            end
          end
        end
        DATA: begin
          if (baud) begin
            if (bit_end) begin
              s         <= '0;
              shift_reg <= shift_reg >> 1;
              if (n == N_LAST) begin
                state <= STOP;
                tx    <= 1'b1;
              end else begin
                n  <= n + NW'(1);
                tx <= shift_reg[1];
              end
            end else begin
              s <= s + SW'(1);
            end
          end
        end
        STOP: begin
          if (baud) begin
            if (stop_end) begin
              s       <= '0;
              tx_done <= 1'b1;
              if (hold_valid) begin
                shift_reg <= hold_data;
                state     <= START;
                tx        <= 1'b0;
              end else if (accept) begin
                shift_reg <= d_in;
                state     <= START;
                tx        <= 1'b0;
              end else begin
                state   <= IDLE;
                tx_busy <= 1'b0;
              end
            end else begin
              s <= s + SW'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench: a tick-level frame model predicts ready/busy/done and the
// byte order; a line decoder pops the expected bytes as frames arrive.
module tb_uart_tx_buffered;

  localparam int OS       = 16;
  localparam int SB       = 16;
  localparam int DB       = 8;
  localparam int FRAME    = (1 + DB) * OS + SB;
  localparam int DB2      = 7;
  localparam int SB2      = 32;
  localparam int FRAME2   = (1 + DB2) * OS + SB2;
  localparam int BAUD_DIV = 4;

  logic       clk;
  logic       rst_n;
  logic       baud;
  logic       tx_start;
  logic [7:0] d_in;
  logic       tx, tx_ready, tx_busy, tx_done;
  logic       tx_start2;
  logic [6:0] d_in2;
  logic       tx2, tx_ready2, tx_busy2, tx_done2;

  int         n_checks;
  int         n_fails;
  int         m_pending;
  int         m_remaining;
  bit         m_done;
  logic [7:0] exp_q[$];
  bit         mon_in_frame;
  bit         rand_baud;
  int         div_cnt;

  uart_tx_buffered #(.DATA_BITS(DB), .OVERSAMPLE(OS), .SB_TICKS(SB)) dut (
    .clk(clk), .rst_n(rst_n), .baud(baud), .tx_start(tx_start), .d_in(d_in),
    .tx(tx), .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  uart_tx_buffered #(.DATA_BITS(DB2), .OVERSAMPLE(OS), .SB_TICKS(SB2)) dut2 (
    .clk(clk), .rst_n(rst_n), .baud(baud), .tx_start(tx_start2), .d_in(d_in2),
    .tx(tx2), .tx_ready(tx_ready2), .tx_busy(tx_busy2), .tx_done(tx_done2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic failNow(input string name);
    n_checks++;
    n_fails++;
    $display("[TB] FAIL %s at %0t", name, $time);
  endtask

  // Reference model: each accepted byte occupies FRAME baud ticks; at most
  // one frame on the line plus one waiting.
  initial begin
    bit rdy;
    m_pending = 0; m_remaining = 0; m_done = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_pending = 0; m_remaining = 0; m_done = 0;
        exp_q.delete();
      end else begin
        rdy    = (m_pending < 2);
        m_done = 0;
        if (baud && m_pending > 0) begin
          m_remaining--;
          if (m_remaining == 0) begin
            m_done = 1;
            m_pending--;
            if (m_pending > 0) m_remaining = FRAME;
          end
        end
        if (tx_start && rdy) begin
          m_pending++;
          exp_q.push_back(d_in);
          if (m_pending == 1) m_remaining = FRAME;
        end
      end
    end
  end

  // Line decoder: samples each bit at its mid-point in baud ticks.
  initial begin
    int cnt;
    bit pend;
    logic [7:0] bits;
    cnt = 0; pend = 0; bits = '0; mon_in_frame = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_in_frame = 0;
        pend = 0;
      end else begin
        if (mon_in_frame && pend) begin
          cnt++;
          if (cnt == OS / 2) begin
            checkOutput("start bit", 32'(tx), 32'(0));
          end else if (cnt > OS && cnt < OS * (DB + 1) && (cnt % OS) == OS / 2) begin
            bits = {tx, bits[7:1]};
          end else if (cnt == OS * (DB + 1) + SB / 2) begin
            checkOutput("stop bit", 32'(tx), 32'(1));
            if (exp_q.size() == 0) failNow("unexpected frame on line");
            else checkOutput("frame data", 32'(bits), 32'(exp_q.pop_front()));
            mon_in_frame = 0;
          end
        end else if (!mon_in_frame && tx == 1'b0) begin
          mon_in_frame = 1;
          cnt = 0;
        end
        pend = baud;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        checkOutput("tx_ready", 32'(tx_ready), 32'(m_pending < 2));
        checkOutput("tx_busy", 32'(tx_busy), 32'(m_pending > 0));
        checkOutput("tx_done", 32'(tx_done), 32'(m_done));
        if (m_pending == 0) checkOutput("idle line", 32'(tx), 32'(1));
      end
    end
  end

  task automatic get_baud(output bit b);
    if (rand_baud) begin
      b = ($urandom_range(0, 2) == 0);
    end else begin
      div_cnt = (div_cnt + 1) % BAUD_DIV;
      b = (div_cnt == 0);
    end
  endtask

  task automatic applyStimulus(input bit b, input bit st, input logic [7:0] d,
                               input bit st2, input logic [6:0] d2);
    baud = b; tx_start = st; d_in = d; tx_start2 = st2; d_in2 = d2;
    @(posedge clk);
    #1;
    baud = 1'b0; tx_start = 1'b0; tx_start2 = 1'b0;
  endtask

  task automatic run_cycle(input bit st, input logic [7:0] d);
    bit b;
    get_baud(b);
    applyStimulus(b, st, d, 1'b0, 7'h00);
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) run_cycle(1'b0, 8'h00);
  endtask

  task automatic wait_idle(input int bound);
    int c;
    c = 0;
    while ((m_pending != 0 || mon_in_frame) && c < bound) begin
      run_cycle(1'b0, 8'h00);
      c++;
    end
    checkOutput("wait idle timeout", 32'(m_pending != 0 || mon_in_frame), 32'(0));
  endtask

  // Seven-bit, two-stop-bit instance checked directly against frame arithmetic.
  task automatic send2(input logic [6:0] v);
    logic [6:0] eb;
    int ticks;
    bit b;
    bit fin;
    eb = v; ticks = 0; fin = 0;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, v);
    for (int c = 0; c < 3000 && !fin; c++) begin
      get_baud(b);
      applyStimulus(b, 1'b0, 8'h00, 1'b0, 7'h00);
      if (b) begin
        ticks++;
        if (ticks == OS / 2) begin
          checkOutput("dut2 start bit", 32'(tx2), 32'(0));
        end else if (ticks > OS && ticks < OS * (DB2 + 1) && (ticks % OS) == OS / 2) begin
          checkOutput("dut2 data bit", 32'(tx2), 32'(eb[0]));
          eb = eb >> 1;
        end else if (ticks == OS * (DB2 + 1) + OS / 2 || ticks == OS * (DB2 + 1) + SB2 - OS / 2) begin
          checkOutput("dut2 stop bit", 32'(tx2), 32'(1));
        end
        checkOutput("dut2 done timing", 32'(tx_done2), 32'(ticks == FRAME2));
        if (ticks == FRAME2) fin = 1;
      end else begin
        checkOutput("dut2 done quiet", 32'(tx_done2), 32'(0));
      end
    end
    if (!fin) failNow("dut2 frame timeout");
    checkOutput("dut2 busy after frame", 32'(tx_busy2), 32'(0));
    checkOutput("dut2 ready after frame", 32'(tx_ready2), 32'(1));
  endtask

  initial begin
    logic saved_tx;
    int c;
    n_checks = 0; n_fails = 0;
    rst_n = 1'b0; baud = 1'b0; tx_start = 1'b0; d_in = '0;
    tx_start2 = 1'b0; d_in2 = '0; rand_baud = 0; div_cnt = 0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset tx", 32'(tx), 32'(1));
    checkOutput("reset tx_ready", 32'(tx_ready), 32'(1));
    checkOutput("reset tx_busy", 32'(tx_busy), 32'(0));
    checkOutput("reset tx_done", 32'(tx_done), 32'(0));
    checkOutput("reset dut2 tx_ready", 32'(tx_ready2), 32'(1));
    rst_n = 1'b1;

    $display("[TB] single frame 0x55");
    run(8);
    run_cycle(1'b1, 8'h55);
    wait_idle(3000);

    $display("[TB] back-to-back and hold-full");
    run_cycle(1'b1, 8'hA5);
    run(BAUD_DIV * OS * 3);
    run_cycle(1'b1, 8'h3C);
    run(20);
    run_cycle(1'b1, 8'hFF);
    run(20);
    wait_idle(4000);

    $display("[TB] same-edge accept");
    run_cycle(1'b1, 8'h11);
    c = 0;
    while (!(m_pending == 1 && m_remaining == 1) && c < 3000) begin
      run_cycle(1'b0, 8'h00);
      c++;
    end
    checkOutput("same-edge setup timeout", 32'(m_pending == 1 && m_remaining == 1), 32'(1));
    applyStimulus(1'b1, 1'b1, 8'h81, 1'b0, 7'h00);
    div_cnt = 0;
    wait_idle(3000);

    $display("[TB] baud stall");
    run_cycle(1'b1, 8'h5A);
    run(BAUD_DIV * OS * 2 + 8);
    saved_tx = tx;
    repeat (1000) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 7'h00);
    checkOutput("stall tx", 32'(tx), 32'(saved_tx));
    wait_idle(3000);

    $display("[TB] reset mid-data");
    run_cycle(1'b1, 8'hF0);
    c = 0;
    while ((FRAME - m_remaining) < OS * 4 + OS / 2 && c < 3000) begin
      run_cycle(1'b0, 8'h00);
      c++;
    end
    checkOutput("reset setup timeout", 32'((FRAME - m_remaining) >= OS * 4 + OS / 2), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset tx", 32'(tx), 32'(1));
    checkOutput("async reset tx_ready", 32'(tx_ready), 32'(1));
    checkOutput("async reset tx_busy", 32'(tx_busy), 32'(0));
    checkOutput("async reset tx_done", 32'(tx_done), 32'(0));
    repeat (2) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 7'h00);
    rst_n = 1'b1;
    div_cnt = 0;
    run(8);
    run_cycle(1'b1, 8'h12);
    wait_idle(3000);

    $display("[TB] random traffic");
    rand_baud = 1;
    repeat (8000) run_cycle($urandom_range(0, 149) == 0, 8'($urandom));
    rand_baud = 0;
    wait_idle(6000);

    $display("[TB] seven data bits, two stop bits");
    send2(7'h7F);
    send2(7'($urandom));

    checkOutput("frames left undelivered", 32'(exp_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
